// File: rtl/uart_mmio_if.sv
// Operand-bus view of the UART MMRs: core drives strobe/address/data, peripheral returns
// combinational read data and an address-hit flag used for read-data steering.
interface uart_mmio_if;
   logic        enable;
   logic        rw;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        hit;

   modport master (
      output enable, rw, addr, wdata,
      input  rdata, hit
   );

   modport slave (
      input  enable, rw, addr, wdata,
      output rdata, hit
   );
endinterface

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART with TX/RX byte FIFOs; txd falls one edge after a write into an idle path.
// No bus backpressure: TX pushes into a full FIFO are dropped, RX bytes arriving into a full FIFO set rx_overrun.
module uart_mmio #(
   parameter logic [31:0] BASE         = 32'h200,
   parameter int          CLKS_PER_BIT = 434,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic          clk,
   input  logic          reset,
   uart_mmio_if.slave    bus,
   input  logic          rxd,
   output logic          txd
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = $clog2(CLKS_PER_BIT);
   localparam logic [DW-1:0] BIT_LAST  = DW'(CLKS_PER_BIT - 1);
   localparam logic [DW-1:0] HALF_LAST = DW'(CLKS_PER_BIT / 2 - 1);
   localparam int TXF = 0;
   localparam int RXF = 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

   // ---------------- access decode ----------------
   logic wr_tx, rd_rx, rd_st;
   logic unused_wdata;

   assign wr_tx        = bus.enable &  bus.rw & (bus.addr == BASE);
   assign rd_rx        = bus.enable & ~bus.rw & (bus.addr == BASE + 32'd1);
   assign rd_st        = bus.enable & ~bus.rw & (bus.addr == BASE + 32'd2);
   assign bus.hit      = bus.enable & (bus.addr >= BASE) & (bus.addr <= BASE + 32'd2);
   assign unused_wdata = ^bus.wdata[31:8];

   // ---------------- FIFOs (index TXF / RXF) ----------------
   logic [1:0]    f_in_vld, f_out_rdy, f_out_vld;
   logic [7:0]    f_in_dat  [2];
   logic [7:0]    f_out_dat [2];
   logic [CW-1:0] f_count   [2];

   for (genvar g = 0; g < 2; g++) begin : g_fifo
      logic [7:0]    mem [FIFO_DEPTH];
      logic [AW-1:0] wr_ptr, rd_ptr;
      logic          do_push, do_pop;

      assign f_out_vld[g] = (f_count[g] != '0);
      assign do_pop       = f_out_rdy[g] & f_out_vld[g];
      // A full FIFO still accepts a push when a pop frees a slot on the same edge.
      assign do_push      = f_in_vld[g] & ((f_count[g] != CW'(FIFO_DEPTH)) | do_pop);
      assign f_out_dat[g] = mem[rd_ptr];

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            f_count[g] <= '0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push & ~do_pop)      f_count[g] <= f_count[g] + CW'(1);
            else if (do_pop & ~do_push) f_count[g] <= f_count[g] - CW'(1);
         end
      end

      always_ff @(posedge clk) begin
         if (do_push) mem[wr_ptr] <= f_in_dat[g];
      end
   end

   // ---------------- TX FSM ----------------
   uart_state_e   tx_state, tx_state_n;
   logic [DW-1:0] tx_div, tx_div_n;
   logic [2:0]    tx_bit, tx_bit_n;
   logic [7:0]    tx_sh, tx_sh_n;
   logic          txd_n, tx_pop;
   logic          tx_bit_done;

   assign tx_bit_done   = (tx_div == BIT_LAST);
   assign f_in_vld[TXF] = wr_tx;
   assign f_in_dat[TXF] = bus.wdata[7:0];
   assign f_out_rdy[TXF] = tx_pop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state <= S_IDLE;
         tx_div   <= '0;
         tx_bit   <= '0;
         tx_sh    <= '0;
         txd      <= 1'b1;
      end else begin
         tx_state <= tx_state_n;
         tx_div   <= tx_div_n;
         tx_bit   <= tx_bit_n;
         tx_sh    <= tx_sh_n;
         txd      <= txd_n;
      end
   end

   always_comb begin
      tx_state_n = tx_state;
      tx_div_n   = tx_div;
      tx_bit_n   = tx_bit;
      tx_sh_n    = tx_sh;
      txd_n      = txd;
      tx_pop     = 1'b0;
      case (tx_state)
         S_IDLE: begin
            txd_n = 1'b1;
            if (f_out_vld[TXF]) begin
               tx_pop     = 1'b1;
               tx_sh_n    = f_out_dat[TXF];
               tx_div_n   = '0;
               tx_state_n = S_START;
               txd_n      = 1'b0;
            end
         end
         S_START: begin
            if (tx_bit_done) begin
               tx_div_n   = '0;
               tx_bit_n   = '0;
               tx_state_n = S_DATA;
               txd_n      = tx_sh[0];
            end else begin
               tx_div_n = tx_div + DW'(1);
            end
         end
         S_DATA: begin
            if (tx_bit_done) begin
               tx_div_n = '0;
               if (tx_bit == 3'd7) begin
                  tx_state_n = S_STOP;
                  txd_n      = 1'b1;
               end else begin
                  tx_bit_n = tx_bit + 3'd1;
                  tx_sh_n  = tx_sh >> 1;
                  txd_n    = tx_sh[1];
               end
            end else begin
               tx_div_n = tx_div + DW'(1);
            end
         end
         S_STOP: begin
            if (tx_bit_done) begin
               tx_div_n = '0;
               // Chain straight into the next start bit so queued bytes leave with no idle gap.
               if (f_out_vld[TXF]) begin
                  tx_pop     = 1'b1;
                  tx_sh_n    = f_out_dat[TXF];
                  tx_state_n = S_START;
                  txd_n      = 1'b0;
               end else begin
                  tx_state_n = S_IDLE;
                  txd_n      = 1'b1;
               end
            end else begin
               tx_div_n = tx_div + DW'(1);
            end
         end
         default: tx_state_n = S_IDLE;
      endcase
   end

   // ---------------- RX synchronizer + FSM ----------------
   logic          rs_meta, rs;
   uart_state_e   rx_state, rx_state_n;
   logic [DW-1:0] rx_div, rx_div_n;
   logic [2:0]    rx_bit, rx_bit_n;
   logic [7:0]    rx_sh, rx_sh_n;
   logic          rx_push, ferr_set;

   assign f_in_vld[RXF]  = rx_push;
   assign f_in_dat[RXF]  = rx_sh;
   assign f_out_rdy[RXF] = rd_rx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rs_meta  <= 1'b1;
         rs       <= 1'b1;
         rx_state <= S_IDLE;
         rx_div   <= '0;
         rx_bit   <= '0;
         rx_sh    <= '0;
      end else begin
         rs_meta  <= rxd;
         rs       <= rs_meta;
         rx_state <= rx_state_n;
         rx_div   <= rx_div_n;
         rx_bit   <= rx_bit_n;
         rx_sh    <= rx_sh_n;
      end
   end

   always_comb begin
      rx_state_n = rx_state;
      rx_div_n   = rx_div;
      rx_bit_n   = rx_bit;
      rx_sh_n    = rx_sh;
      rx_push    = 1'b0;
      ferr_set   = 1'b0;
      case (rx_state)
         S_IDLE: begin
            if (!rs) begin
               rx_div_n   = '0;
               rx_state_n = S_START;
            end
         end
         S_START: begin
            // Half-bit check rejects short low glitches and centres later samples.
            if (rx_div == HALF_LAST) begin
               rx_div_n   = '0;
               rx_bit_n   = '0;
               rx_state_n = rs ? S_IDLE : S_DATA;
            end else begin
               rx_div_n = rx_div + DW'(1);
            end
         end
         S_DATA: begin
            if (rx_div == BIT_LAST) begin
               rx_div_n = '0;
               rx_sh_n  = {rs, rx_sh[7:1]};
               if (rx_bit == 3'd7) rx_state_n = S_STOP;
               else                rx_bit_n   = rx_bit + 3'd1;
            end else begin
               rx_div_n = rx_div + DW'(1);
            end
         end
         S_STOP: begin
            if (rx_div == BIT_LAST) begin
               rx_div_n   = '0;
               rx_push    = rs;
               ferr_set   = ~rs;
               rx_state_n = S_IDLE;
            end else begin
               rx_div_n = rx_div + DW'(1);
            end
         end
         default: rx_state_n = S_IDLE;
      endcase
   end

   // ---------------- status ----------------
   logic rx_overrun, frame_err, ovr_set;
   logic tx_full, tx_empty, tx_busy, rx_avail;

   assign tx_full  = (f_count[TXF] == CW'(FIFO_DEPTH));
   assign tx_empty = (f_count[TXF] == '0);
   assign tx_busy  = (tx_state != S_IDLE);
   assign rx_avail = f_out_vld[RXF];
   assign ovr_set  = rx_push & (f_count[RXF] == CW'(FIFO_DEPTH)) & ~rd_rx;

   // A set on the same edge as a status read wins over the clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_overrun <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_overrun <= ovr_set  | (rx_overrun & ~rd_st);
         frame_err  <= ferr_set | (frame_err  & ~rd_st);
      end
   end

   always_comb begin
      bus.rdata = 32'b0;
      if (rd_rx)
         bus.rdata = {rx_avail, 23'b0, rx_avail ? f_out_dat[RXF] : 8'h00};
      else if (rd_st)
         bus.rdata = {26'b0, frame_err, tx_busy, rx_overrun, rx_avail, tx_empty, tx_full};
   end

endmodule

// File: doc/uart_mmio.md
Name: uart_mmio

Overview:
Memory-mapped 8N1 UART peripheral on the core's operand bus, driving the top-level txd/rxd pins. It sits beside the RAM, Seg7 and video MMRs. The core writes bytes into a TX FIFO and reads received bytes from an RX FIFO. The top level uses `hit` to steer read data onto the operand bus.

Parameters:
BASE, 32'h200, word address of register 0 (TX data); RX data at BASE+1, status at BASE+2.
CLKS_PER_BIT, 434, clk cycles per bit time (50 MHz / 115200); minimum 4.
FIFO_DEPTH, 8, entries per FIFO; power of two, minimum 2.

Ports:
clk  in  1  core data-side clock; all state on rising edge.
reset  in  1  asynchronous, active-high; clears all state.
enable  in  1  bus access strobe, one access per cycle.
rw  in  1  1 = write, 0 = read (same sense as operand_rw).
addr  in  32  word address.
wdata  in  32  write data; only [7:0] used.
rdata  out  32  read data (combinational).
hit  out  1  enable && addr in [BASE, BASE+2].
rxd  in  1  serial input, asynchronous to clk.
txd  out  1  serial output, idles high.

Behaviour:
- Reset (async): txd=1; both FIFOs empty; sticky flags 0; TX/RX FSMs in IDLE; bit counters and dividers 0; rxd synchronizer flops = 1.
- Access decode:
  - wr_tx = enable & rw & addr==BASE.
  - rd_rx = enable & ~rw & addr==BASE+1.
  - rd_st = enable & ~rw & addr==BASE+2.
  - Writes to BASE+1 and BASE+2 are ignored.
- rdata, combinational:
  - rd_rx: {rx_nonempty, 23'b0, rx_head[7:0]}.
  - rd_st: {26'b0, frame_err, tx_busy, rx_overrun, rx_avail, tx_empty, tx_full}.
  - Otherwise 32'b0.
- TX FIFO:
  - wr_tx pushes wdata[7:0] at the edge.
  - A push while full is dropped silently, unless the FSM pops on the same edge; then it is accepted.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE with FIFO non-empty: pop, load shift register, go to START.
  - START: txd=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each.
  - STOP: txd=1 for CLKS_PER_BIT cycles.
  - From STOP: return to IDLE, or go straight to START with the next popped byte if the FIFO is non-empty. Back-to-back frames have no extra idle cycles.
  - Latency: a write captured at edge E into an empty FIFO with FSM idle gives txd=0 after edge E+1.
  - tx_busy = FSM != IDLE.
  - txd is a registered output.
- RX path: rxd passes through a 2-flop synchronizer (rs).
- RX FSM: IDLE -> START -> DATA -> STOP.
  - IDLE: on rs==0, go to START and count CLKS_PER_BIT/2 cycles.
  - START: at mid-point, if rs==1 it was a glitch; return to IDLE. Otherwise go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first.
  - STOP: after one more CLKS_PER_BIT, sample the stop bit.
    - Stop bit 1: push byte.
    - Stop bit 0: discard byte and set frame_err.
  - In all cases return to IDLE.
- RX FIFO:
  - rd_rx pops at the edge when non-empty; reading empty does not pop and returns bit31=0.
  - Push while full (no simultaneous pop): byte dropped and rx_overrun set.
  - Push and pop on the same edge: both occur; count unchanged, including when full.
- Sticky flags (rx_overrun, frame_err) clear at the edge of rd_st. A set event on that same edge wins (flag stays 1). The status value read in that cycle shows the pre-clear value.
- Flags:
  - rx_avail = RX count != 0.
  - tx_full = TX count == FIFO_DEPTH.
  - tx_empty = TX count == 0.
- Pointers wrap modulo FIFO_DEPTH. Each FIFO has an explicit log2(FIFO_DEPTH)+1-bit count.
- Reset mid-frame:
  - txd goes to 1 immediately; the partial frame is abandoned.
  - The RX partial byte is discarded.

Test Plan:
- Reset, CLKS_PER_BIT=4: txd=1, status reads 32'h2, rd_rx returns 32'h0, hit=0 with enable=0.
- Write 8'hA5 to BASE: txd low from E+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high. tx_busy=1 throughout; status back to 32'h2 after stop.
- Write 9 bytes back-to-back, FSM idle, depth 8: the first is popped immediately, so all 9 are transmitted with no idle gap between stop and start. A 10th write in the same burst is dropped once tx_full=1.
- Drive rxd with frame 8'h3C at 4 clk/bit: status bit2=1, rd_rx returns 32'h8000003C, the next rd_rx returns 32'h0.
- Send 9 frames without reading: status shows overrun (bit3) and 8 bytes readable in order. Read status twice: bit3=1, then 0.
- Frame with stop bit 0: no push, frame_err (bit5) set. A 1-cycle low glitch on idle rxd produces no byte and no flag. Assert reset mid-TX-frame: txd=1 in the same cycle.
